nr_memory: RTL and testbench

NR_MEMORY -- requirements
Module: nr_memory

---
 rtl/nr_memory.sv | 61 ++++++
 tb/tb_nr_memory.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nr_memory.sv
// nr_memory: 2^ADDR_W x DATA_W flip-flop register file.
// It has one write port and one registered read port with 1-cycle read latency.
// clr synchronously zeroes the whole array and the output register in a single cycle.
// Optional build macro NR_MEMORY_WRITE_BYPASS_EN changes same-address read/write
// collisions from read-before-write to write-first. In write-first mode the read
// port returns the incoming write data.
module nr_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  input  logic [ADDR_W-1:0] Adrin,
  input  logic [ADDR_W-1:0] Adrout,
  input  logic              canWr,
  input  logic              canRd
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;

  // Array update: clear wins over write; without clr or canWr every word holds
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (canWr) begin
      mem[Adrin] <= in;
    end
  end

`ifdef NR_MEMORY_WRITE_BYPASS_EN
  // Read mux, write-first: a same-cycle write to the read address forwards its data
  always_comb begin
    rd_data = mem[Adrout];
    if (canWr && (Adrin == Adrout)) begin
      rd_data = in;
    end
  end
`else
  // Read mux, read-before-write: the array value ahead of this edge's write
  always_comb begin
    rd_data = mem[Adrout];
  end
`endif

  // Output register: cleared by clr, loaded on canRd, otherwise held
  always_ff @(posedge clk) begin
    if (clr) begin
      out <= '0;
    end else if (canRd) begin
      out <= rd_data;
    end
  end

endmodule

// File: tb/tb_nr_memory.sv
// Self-checking bench for nr_memory (default 8-bit data, 8-bit address).
// Each step drives one cycle of inputs and pushes the expected out value onto
// a scoreboard queue. After the edge, the value is popped and compared.
// Build with NR_MEMORY_WRITE_BYPASS_EN defined to expect write-first collisions.
module tb_nr_memory;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] in = '0;
  logic [7:0] out;
  logic [7:0] Adrin = '0;
  logic [7:0] Adrout = '0;
  logic       canWr = 1'b0;
  logic       canRd = 1'b0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] ref_mem [256];
  logic [7:0] model_out;
  int         errors = 0;
  int         checks = 0;

  nr_memory #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk    (clk),
    .clr    (clr),
    .in     (in),
    .out    (out),
    .Adrin  (Adrin),
    .Adrout (Adrout),
    .canWr  (canWr),
    .canRd  (canRd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic c, input logic w, input logic [7:0] wa,
                      input logic [7:0] wd, input logic r, input logic [7:0] ra,
                      input string tag);
    sb_t e;
    clr = c; canWr = w; Adrin = wa; in = wd; canRd = r; Adrout = ra;
    if (c) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      model_out = '0;
    end else begin
      if (r) begin
        model_out = ref_mem[ra];
`ifdef NR_MEMORY_WRITE_BYPASS_EN
        if (w && (wa == ra)) model_out = wd;
`endif
      end
      if (w) ref_mem[wa] = wd;
    end
    sb.push_back('{tag, model_out});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (out === e.val) else begin
      errors++;
      $error("FAIL %s: out=%02h expected %02h", e.tag, out, e.val);
    end
  endtask

  task automatic expect_lit(input string tag, input logic [7:0] v);
    checks++;
    assert (out === v) else begin
      errors++;
      $error("FAIL %s: out=%02h expected %02h", tag, out, v);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    step(1, 0, 0, 0, 0, 0, "clr_init");
    expect_lit("clr_init_lit", 8'h00);

    // Write then read
    step(0, 1, 5, 8'h2A, 0, 0, "wr5");
    step(0, 0, 0, 0, 1, 5, "rd5");
    expect_lit("rd5_lit", 8'h2A);

    // Read hold
    step(0, 1, 3, 8'h07, 0, 0, "wr3_hold");
    step(0, 0, 0, 0, 0, 3, "hold_rd_off");
    expect_lit("hold_lit", 8'h2A);
    step(0, 0, 0, 0, 1, 3, "rd3");
    expect_lit("rd3_lit", 8'h07);

    // Write disable
    for (int i = 0; i < 10; i++) step(0, 0, 5, 8'hFF, 0, 3, "wr_dis");
    step(0, 0, 5, 8'hFF, 1, 5, "rd5_after_dis");
    expect_lit("wr_dis_lit", 8'h2A);

    // Same-address collision
    step(0, 1, 9, 8'h11, 0, 0, "wr9");
    step(0, 1, 9, 8'h22, 1, 9, "collide9");
`ifdef NR_MEMORY_WRITE_BYPASS_EN
    expect_lit("collide9_lit", 8'h22);
`else
    expect_lit("collide9_lit", 8'h11);
`endif
    step(0, 0, 0, 0, 1, 9, "rd9_after");
    expect_lit("rd9_after_lit", 8'h22);

    // Independent read and write at different addresses
    step(0, 1, 10, 8'h33, 1, 3, "wr10_rd3");
    step(0, 0, 0, 0, 1, 10, "rd10");

    // Top address and distinctness from word 0
    step(0, 1, 255, 8'h55, 0, 0, "wr255");
    step(0, 0, 0, 0, 1, 255, "rd255");
    expect_lit("rd255_lit", 8'h55);
    step(0, 0, 0, 0, 1, 0, "rd0_not_255");

    // Clear: fill 0..15, then clr with a competing write that must be discarded
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 8'(i + 1), 0, 0, "fill");
    step(0, 0, 0, 0, 1, 15, "rd15_filled");
    expect_lit("rd15_filled_lit", 8'h10);
    step(1, 1, 20, 8'h77, 1, 4, "clr_with_wr");
    expect_lit("clr_out_lit", 8'h00);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 8'(i), "rd_cleared");
    step(0, 0, 0, 0, 1, 20, "rd20_discarded");
    step(0, 0, 0, 0, 1, 255, "rd255_cleared");
    expect_lit("rd255_cleared_lit", 8'h00);

    // Recovery right after clr, then collision on a cleared word
    step(1, 0, 0, 0, 0, 0, "clr2");
    step(0, 1, 7, 8'h99, 1, 7, "post_clr_collide");
    step(0, 0, 0, 0, 1, 7, "rd7");
    expect_lit("rd7_lit", 8'h99);

    // Mixed traffic over a small address window to provoke collisions
    for (int i = 0; i < 60; i++) begin
      step(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), "mixed");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
